// File: rtl/instruction_fetch.sv
// Fetch stage: issues PC reads under a credit limit, tags returned data with
// its PC, buffers it in order and hands it to decode. Flush drops queued
// entries and any reads still in flight.
module instruction_fetch #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 16,
    parameter int unsigned DW    = 16
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic [AW-1:0] PcValue,
    output logic          PcAdvance,
    output logic          MemReqValid,
    input  logic          MemReqReady,
    output logic [AW-1:0] MemAddr,
    input  logic          MemRspValid,
    input  logic [DW-1:0] MemRspData,
    output logic          InstrValid,
    input  logic          InstrReady,
    output logic [DW-1:0] Instr,
    output logic [AW-1:0] InstrPc,
    input  logic          Flush
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;
    logic [CW-1:0] w_count_nxt;
    logic [CW-1:0] w_outstanding_nxt;
    logic [CW-1:0] w_discard_nxt;
    logic          r_rst_q;

    logic [AW-1:0] r_tag_mem [DEPTH];
    logic [PW-1:0] r_tag_wr;
    logic [PW-1:0] r_tag_rd;

    logic [DW-1:0] r_data_mem [DEPTH];
    logic [AW-1:0] r_pc_mem   [DEPTH];
    logic [PW-1:0] r_q_wr;
    logic [PW-1:0] r_q_rd;

    logic [CW:0]   w_inflight;
    logic          w_accept;
    logic          w_rsp_keep;
    logic          w_push;
    logic          w_pop;

    // Credit check, handshakes and queue-head outputs
    always_comb begin
        w_inflight  = {1'b0, r_count} + {1'b0, r_outstanding};
        MemReqValid = (r_state == RUN) && !Flush && !r_rst_q &&
                      (w_inflight < (CW+1)'(DEPTH));
        w_accept    = MemReqValid && MemReqReady;
        PcAdvance   = w_accept;
        MemAddr     = PcValue;
        InstrValid  = (r_count != '0);
        Instr       = r_data_mem[r_q_rd];
        InstrPc     = r_pc_mem[r_q_rd];
        w_rsp_keep  = MemRspValid && (r_discard == '0);
        w_push      = w_rsp_keep && !Flush;
        w_pop       = InstrValid && InstrReady && !Flush;
    end

    // Next-state: counters, discard budget and RUN/DRAIN transitions
    always_comb begin
        w_state_nxt       = r_state;
        w_count_nxt       = r_count;
        w_discard_nxt     = r_discard;
        w_outstanding_nxt = r_outstanding + CW'(w_accept) - CW'(MemRspValid);

        if (Flush) begin
            w_count_nxt   = '0;
            // a response landing in the flush cycle is itself dropped
            w_discard_nxt = r_outstanding - CW'(MemRspValid);
        end else begin
            w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
            if (MemRspValid && (r_discard != '0)) begin
                w_discard_nxt = r_discard - CW'(1);
            end
        end

        case (r_state)
            RUN: begin
                if (Flush && (w_discard_nxt != '0)) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_discard_nxt == '0) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    // State, counters and queue pointers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state       <= RUN;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_rst_q       <= 1'b1;
            r_tag_wr      <= '0;
            r_tag_rd      <= '0;
            r_q_wr        <= '0;
            r_q_rd        <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_count       <= w_count_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_discard     <= w_discard_nxt;
            r_rst_q       <= 1'b0;
            if (Flush) begin
                r_tag_wr <= '0;
                r_tag_rd <= '0;
                r_q_wr   <= '0;
                r_q_rd   <= '0;
            end else begin
                if (w_accept)   r_tag_wr <= r_tag_wr + PW'(1);
                if (w_rsp_keep) r_tag_rd <= r_tag_rd + PW'(1);
                if (w_push)     r_q_wr   <= r_q_wr + PW'(1);
                if (w_pop)      r_q_rd   <= r_q_rd + PW'(1);
            end
        end
    end

    // Tag and prefetch storage; contents are qualified by the pointers
    always_ff @(posedge Clock) begin
        if (w_accept) begin
            r_tag_mem[r_tag_wr] <= PcValue;
        end
        if (w_push) begin
            r_data_mem[r_q_wr] <= MemRspData;
            r_pc_mem[r_q_wr]   <= r_tag_mem[r_tag_rd];
        end
    end

    // Credit never exceeds the queue size
    a_credit: assert property (@(posedge Clock) disable iff (Reset)
        w_inflight <= (CW+1)'(DEPTH));

    // Memory only answers reads that were actually issued
    a_no_orphan_rsp: assert property (@(posedge Clock) disable iff (Reset)
        MemRspValid |-> (r_outstanding != '0));

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: behavioural memory with
// configurable latency and a scoreboard of expected {pc, data} deliveries.
module tb_instruction_fetch;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 16;

    typedef struct {
        int            due;
        logic [AW-1:0] addr;
        bit            live;
    } mem_ent_t;

    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] data;
    } exp_ent_t;

    logic          Clock;
    logic          Reset;
    logic [AW-1:0] PcValue;
    logic          PcAdvance;
    logic          MemReqValid;
    logic          MemReqReady;
    logic [AW-1:0] MemAddr;
    logic          MemRspValid;
    logic [DW-1:0] MemRspData;
    logic          InstrValid;
    logic          InstrReady;
    logic [DW-1:0] Instr;
    logic [AW-1:0] InstrPc;
    logic          Flush;

    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    int            lat = 1;
    int            acc_total = 0;
    int            first_acc_cyc = -1;
    int            first_pop_cyc = -1;
    bit            rst_hold = 1'b1;
    mem_ent_t      mem_q[$];
    exp_ent_t      exp_q[$];
    logic [AW-1:0] popped[$];

    instruction_fetch #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .PcValue     (PcValue),
        .PcAdvance   (PcAdvance),
        .MemReqValid (MemReqValid),
        .MemReqReady (MemReqReady),
        .MemAddr     (MemAddr),
        .MemRspValid (MemRspValid),
        .MemRspData  (MemRspData),
        .InstrValid  (InstrValid),
        .InstrReady  (InstrReady),
        .Instr       (Instr),
        .InstrPc     (InstrPc),
        .Flush       (Flush)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    function automatic bit any_dead();
        foreach (mem_q[i]) if (!mem_q[i].live) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: check outputs mid-cycle, update model, drive next inputs
    task automatic cycle();
        bit       acc;
        bit       exp_req;
        exp_ent_t e;
        mem_ent_t m;
        @(negedge Clock);
        acc = (MemReqValid === 1'b1) && (MemReqReady === 1'b1);
        if (!Reset) begin
            n_checks++;
            if (PcAdvance !== acc) begin
                n_errors++;
                $display("FAIL pc_advance cyc=%0d got=%b exp=%b", cyc, PcAdvance, acc);
            end
            n_checks++;
            if (MemAddr !== PcValue) begin
                n_errors++;
                $display("FAIL mem_addr cyc=%0d got=%h exp=%h", cyc, MemAddr, PcValue);
            end
            exp_req = !rst_hold && !Flush && !any_dead() &&
                      ((exp_q.size() + mem_q.size()) < DEPTH);
            n_checks++;
            if (MemReqValid !== exp_req) begin
                n_errors++;
                $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, MemReqValid, exp_req);
            end
            n_checks++;
            if (InstrValid !== (exp_q.size() != 0)) begin
                n_errors++;
                $display("FAIL instr_valid cyc=%0d got=%b exp=%b", cyc, InstrValid, exp_q.size() != 0);
            end
            if (InstrValid === 1'b1 && exp_q.size() != 0) begin
                n_checks++;
                if (InstrPc !== exp_q[0].pc || Instr !== exp_q[0].data) begin
                    n_errors++;
                    $display("FAIL head cyc=%0d got pc=%h data=%h exp pc=%h data=%h",
                             cyc, InstrPc, Instr, exp_q[0].pc, exp_q[0].data);
                end
                if (InstrReady && !Flush) begin
                    e = exp_q.pop_front();
                    popped.push_back(InstrPc);
                    if (first_pop_cyc < 0) first_pop_cyc = cyc;
                end
            end
            if (MemRspValid && mem_q.size() != 0) begin
                m = mem_q.pop_front();
                if (m.live && !Flush) exp_q.push_back('{pc: m.addr, data: mem_data(m.addr)});
            end
            if (acc) begin
                mem_q.push_back('{due: cyc + lat, addr: MemAddr, live: 1'b1});
                acc_total++;
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
            end
            if (Flush) begin
                exp_q.delete();
                foreach (mem_q[i]) mem_q[i].live = 1'b0;
            end
        end
        rst_hold = Reset;
        if (Reset) begin
            exp_q.delete();
            mem_q.delete();
        end
        @(posedge Clock);
        #1;
        cyc++;
        if (acc && !Reset) PcValue = PcValue + AW'(1);
        MemRspValid = (mem_q.size() != 0) && (mem_q[0].due == cyc);
        MemRspData  = MemRspValid ? mem_data(mem_q[0].addr) : DW'($urandom);
    endtask

    task automatic do_reset(input int n);
        Reset       = 1'b1;
        Flush       = 1'b0;
        MemReqReady = 1'b0;
        InstrReady  = 1'b0;
        repeat (n) cycle();
        Reset = 1'b0;
    endtask

    // Count cycles with no request after a flush, bounded
    task automatic drain_len(output int n);
        n = 0;
        while (MemReqValid !== 1'b1 && n < 20) begin
            n++;
            cycle();
        end
    endtask

    task automatic test_reset();
        PcValue = 16'h0100;
        do_reset(2);
        n_checks++;
        if (InstrValid !== 1'b0 || MemReqValid !== 1'b0 || PcAdvance !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs got valid=%b req=%b adv=%b exp 0 0 0",
                     InstrValid, MemReqValid, PcAdvance);
        end
    endtask

    task automatic test_stream();
        int a0;
        do_reset(1);
        PcValue = 16'h0100; lat = 1; MemReqReady = 1'b1; InstrReady = 1'b1;
        popped.delete(); first_acc_cyc = -1; first_pop_cyc = -1; a0 = acc_total;
        repeat (12) cycle();
        n_checks++;
        if (acc_total - a0 != 11) begin
            n_errors++;
            $display("FAIL stream_accepts got=%0d exp=11", acc_total - a0);
        end
        n_checks++;
        if (popped.size() != 9) begin
            n_errors++;
            $display("FAIL stream_pops got=%0d exp=9", popped.size());
        end
        n_checks++;
        if (popped.size() < 3 || popped[0] !== 16'h0100 || popped[1] !== 16'h0101 ||
            popped[2] !== 16'h0102) begin
            n_errors++;
            $display("FAIL stream_order got first=%h exp 0100,0101,0102",
                     popped.size() ? popped[0] : 16'hxxxx);
        end
        n_checks++;
        if (first_pop_cyc - first_acc_cyc != 2) begin
            n_errors++;
            $display("FAIL stream_fill got=%0d exp=2", first_pop_cyc - first_acc_cyc);
        end
    endtask

    task automatic test_backpressure();
        int a0, p0, s0;
        do_reset(1);
        PcValue = 16'h0100; lat = 1; MemReqReady = 1'b1; InstrReady = 1'b0;
        a0 = acc_total;
        repeat (12) cycle();
        n_checks++;
        if (acc_total - a0 != DEPTH) begin
            n_errors++;
            $display("FAIL bp_accepts got=%0d exp=%0d", acc_total - a0, DEPTH);
        end
        n_checks++;
        if (MemReqValid !== 1'b0 || PcAdvance !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_stall got req=%b adv=%b exp 0 0", MemReqValid, PcAdvance);
        end
        n_checks++;
        if (InstrValid !== 1'b1 || InstrPc !== 16'h0100 || Instr !== mem_data(16'h0100)) begin
            n_errors++;
            $display("FAIL bp_hold got valid=%b pc=%h data=%h exp 1 0100 %h",
                     InstrValid, InstrPc, Instr, mem_data(16'h0100));
        end
        InstrReady = 1'b1;
        a0 = acc_total; p0 = popped.size(); s0 = exp_q.size() + mem_q.size();
        repeat (8) cycle();
        n_checks++;
        if ((acc_total - a0) != (popped.size() - p0) + (exp_q.size() + mem_q.size() - s0) ||
            acc_total == a0) begin
            n_errors++;
            $display("FAIL bp_resume got accepts=%0d pops=%0d", acc_total - a0, popped.size() - p0);
        end
    endtask

    task automatic test_flush();
        int a0, n, p0, guard, bad;
        do_reset(1);
        PcValue = 16'h0100; lat = 4; MemReqReady = 1'b1; InstrReady = 1'b0;
        a0 = acc_total; guard = 0;
        while (acc_total - a0 < 3 && guard < 20) begin
            guard++;
            cycle();
        end
        n_checks++;
        if (acc_total - a0 != 3) begin
            n_errors++;
            $display("FAIL flush_setup got accepts=%0d exp=3", acc_total - a0);
        end
        Flush = 1'b1; PcValue = 16'h0200; InstrReady = 1'b1;
        p0 = popped.size();
        cycle();
        Flush = 1'b0;
        drain_len(n);
        n_checks++;
        if (n != 3) begin
            n_errors++;
            $display("FAIL flush_drain got=%0d exp=3", n);
        end
        repeat (15) cycle();
        bad = 0;
        for (int i = p0; i < popped.size(); i++) if (popped[i][15:8] == 8'h01) bad++;
        n_checks++;
        if (popped.size() <= p0 || popped[p0] !== 16'h0200 || bad != 0) begin
            n_errors++;
            $display("FAIL flush_first got first=%h stale=%0d exp 0200 0",
                     popped.size() > p0 ? popped[p0] : 16'hxxxx, bad);
        end
    endtask

    task automatic test_flush_collide();
        int guard, exp_disc, n, p0;
        do_reset(1);
        PcValue = 16'h0100; lat = 2; MemReqReady = 1'b1; InstrReady = 1'b1;
        guard = 0;
        while (!(MemRspValid === 1'b1 && InstrValid === 1'b1) && guard < 20) begin
            guard++;
            cycle();
        end
        n_checks++;
        if (guard >= 20) begin
            n_errors++;
            $display("FAIL collide_setup got timeout exp rsp+valid");
        end
        exp_disc = mem_q.size() - 1;
        Flush = 1'b1; PcValue = 16'h0300;
        p0 = popped.size();
        cycle();
        Flush = 1'b0;
        n_checks++;
        if (InstrValid !== 1'b0 || popped.size() != p0) begin
            n_errors++;
            $display("FAIL collide_empty got valid=%b pops=%0d exp 0 0", InstrValid, popped.size() - p0);
        end
        drain_len(n);
        n_checks++;
        if (n != exp_disc) begin
            n_errors++;
            $display("FAIL collide_discard got=%0d exp=%0d", n, exp_disc);
        end
        repeat (10) cycle();
        n_checks++;
        if (popped.size() <= p0 || popped[p0] !== 16'h0300) begin
            n_errors++;
            $display("FAIL collide_first got=%h exp=0300", popped.size() > p0 ? popped[p0] : 16'hxxxx);
        end
    endtask

    task automatic test_random_ready();
        int a0, p0, bad;
        do_reset(1);
        PcValue = 16'h1000; lat = 2;
        a0 = acc_total; p0 = popped.size();
        for (int i = 0; i < 300; i++) begin
            MemReqReady = 1'($urandom_range(0, 1));
            InstrReady  = ($urandom_range(0, 3) != 0);
            cycle();
        end
        MemReqReady = 1'b0; InstrReady = 1'b1;
        repeat (12) cycle();
        n_checks++;
        if (popped.size() - p0 != acc_total - a0 || acc_total == a0) begin
            n_errors++;
            $display("FAIL rand_count got pops=%0d exp=%0d", popped.size() - p0, acc_total - a0);
        end
        bad = 0;
        for (int i = p0; i < popped.size(); i++) begin
            if (popped[i] !== 16'h1000 + AW'(i - p0)) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL rand_sequence got bad=%0d exp=0", bad);
        end
    endtask

    task automatic test_reset_mid();
        int guard, p0;
        do_reset(1);
        PcValue = 16'h0100; lat = 2; MemReqReady = 1'b1; InstrReady = 1'b0;
        guard = 0;
        while (!(exp_q.size() == 2 && mem_q.size() == 2) && guard < 20) begin
            guard++;
            cycle();
        end
        n_checks++;
        if (guard >= 20) begin
            n_errors++;
            $display("FAIL rstmid_setup got q=%0d out=%0d exp 2 2", exp_q.size(), mem_q.size());
        end
        Reset = 1'b1; PcValue = 16'h0400;
        cycle();
        Reset = 1'b0;
        n_checks++;
        if (InstrValid !== 1'b0 || MemReqValid !== 1'b0) begin
            n_errors++;
            $display("FAIL rstmid_outputs got valid=%b req=%b exp 0 0", InstrValid, MemReqValid);
        end
        InstrReady = 1'b1;
        p0 = popped.size();
        repeat (10) cycle();
        n_checks++;
        if (popped.size() <= p0 || popped[p0] !== 16'h0400) begin
            n_errors++;
            $display("FAIL rstmid_resume got=%h exp=0400", popped.size() > p0 ? popped[p0] : 16'hxxxx);
        end
    endtask

    initial begin
        Reset       = 1'b1;
        PcValue     = 16'h0000;
        MemReqReady = 1'b0;
        MemRspValid = 1'b0;
        MemRspData  = '0;
        InstrReady  = 1'b0;
        Flush       = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_flush_collide();
        test_random_ready();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
